// File: rtl/nes_pad_pkg.sv
// rtl/nes_pad_pkg.sv - shared types and constants for the NES pad reader
package nes_pad_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } state_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  // A whole frame plus the tick and DONE cycles must fit inside one poll period.
  function automatic bit params_ok(input int latch_cycles, input int half_bit_cycles,
                                   input int poll_cycles);
    return (latch_cycles > 0) && (half_bit_cycles > 0) &&
           (poll_cycles > latch_cycles + 16 * half_bit_cycles + 2);
  endfunction

endpackage

// File: rtl/nes_pad_reader_pad_sync.sv
// rtl/nes_pad_reader_pad_sync.sv - two-flop synchronizer for pad_data, idles high
module pad_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_pad_reader.sv
// rtl/nes_pad_reader.sv - periodic NES gamepad poller with registered button levels
// Optional macro NES_PAD_SOCD_EN neutralises simultaneous opposite directions.
module nes_pad_reader
  import nes_pad_pkg::*;
#(
  parameter int LATCH_CYCLES    = 300,
  parameter int HALF_BIT_CYCLES = 150,
  parameter int POLL_CYCLES     = 416667
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       left,
  output logic       right,
  output logic       up,
  output logic       down,
  output logic       valid
);

  localparam int POLL_W    = $clog2(POLL_CYCLES);
  localparam int PHASE_MAX = (LATCH_CYCLES > HALF_BIT_CYCLES) ? LATCH_CYCLES : HALF_BIT_CYCLES;
  localparam int PHASE_W   = $clog2(PHASE_MAX + 1);

  localparam logic [POLL_W-1:0]  POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
  localparam logic [PHASE_W-1:0] LATCH_LAST = PHASE_W'(LATCH_CYCLES - 1);
  localparam logic [PHASE_W-1:0] HALF_LAST  = PHASE_W'(HALF_BIT_CYCLES - 1);

  if (!params_ok(LATCH_CYCLES, HALF_BIT_CYCLES, POLL_CYCLES)) begin : g_bad_params
    $error("nes_pad_reader: POLL_CYCLES too small to hold one frame");
  end

  logic               data_sync;
  logic [POLL_W-1:0]  poll_cnt;
  logic               poll_tick;
  state_t             state;
  logic [PHASE_W-1:0] phase;
  logic [2:0]         index;
  logic [7:0]         shift;
  logic               left_next;
  logic               right_next;
  logic               up_next;
  logic               down_next;

  pad_sync u_pad_sync (
    .clk   (clk),
    .reset (reset),
    .d     (pad_data),
    .q     (data_sync)
  );

  // Tick is registered so it is high on the cycle the counter sits at 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      poll_cnt  <= '0;
      poll_tick <= 1'b0;
    end else begin
      poll_tick <= (poll_cnt == POLL_LAST);
      poll_cnt  <= (poll_cnt == POLL_LAST) ? '0 : poll_cnt + 1'b1;
    end
  end

`ifdef NES_PAD_SOCD_EN
  assign left_next  = shift[BTN_LEFT]  & ~shift[BTN_RIGHT];
  assign right_next = shift[BTN_RIGHT] & ~shift[BTN_LEFT];
  assign up_next    = shift[BTN_UP]    & ~shift[BTN_DOWN];
  assign down_next  = shift[BTN_DOWN]  & ~shift[BTN_UP];
`else
  assign left_next  = shift[BTN_LEFT];
  assign right_next = shift[BTN_RIGHT];
  assign up_next    = shift[BTN_UP];
  assign down_next  = shift[BTN_DOWN];
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      phase     <= '0;
      index     <= '0;
      shift     <= '0;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      buttons   <= '0;
      left      <= 1'b0;
      right     <= 1'b0;
      up        <= 1'b0;
      down      <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state)
        IDLE: begin
          if (poll_tick) begin
            state     <= LATCH;
            phase     <= '0;
            index     <= '0;
            pad_latch <= 1'b1;
          end
        end
        LATCH: begin
          if (phase == LATCH_LAST) begin
            phase     <= '0;
            pad_latch <= 1'b0;
            state     <= LOW;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        LOW: begin
          if (phase == HALF_LAST) begin
            phase        <= '0;
            shift[index] <= ~data_sync;
            pad_clk      <= 1'b1;
            state        <= HIGH;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        HIGH: begin
          if (phase == HALF_LAST) begin
            phase   <= '0;
            pad_clk <= 1'b0;
            if (index == 3'd7) begin
              // Outputs load as DONE is entered so they are visible alongside valid.
              state   <= DONE;
              buttons <= shift;
              left    <= left_next;
              right   <= right_next;
              up      <= up_next;
              down    <= down_next;
              valid   <= 1'b1;
            end else begin
              index <= index + 1'b1;
              state <= LOW;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nes_pad_reader.sv
// tb/tb_nes_pad_reader.sv - scoreboard bench for nes_pad_reader with a shift-register pad model
module tb_nes_pad_reader;

  localparam int LATCH = 4;
  localparam int HALF  = 2;
  localparam int POLL  = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       pad_data;
  logic       pad_latch, pad_clk, valid;
  logic       left, right, up, down;
  logic [7:0] buttons;

  logic [7:0] pad_btn   = 8'h00;
  logic [7:0] pad_sr    = 8'h00;
  logic       pclk_d    = 1'b0;
  logic       unplugged = 1'b0;

  logic [11:0] exp_q[$];
  logic [11:0] exp_e;
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  nes_pad_reader #(
    .LATCH_CYCLES    (LATCH),
    .HALF_BIT_CYCLES (HALF),
    .POLL_CYCLES     (POLL)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .buttons   (buttons),
    .left      (left),
    .right     (right),
    .up        (up),
    .down      (down),
    .valid     (valid)
  );

  // Pad: parallel load while latched, shift on pad_clk rise, data low = pressed.
  always @(posedge clk) begin
    if (pad_latch) pad_sr <= pad_btn;
    else if (pad_clk && !pclk_d) pad_sr <= {1'b0, pad_sr[7:1]};
    pclk_d <= pad_clk;
  end
  assign pad_data = unplugged ? 1'b1 : ~pad_sr[0];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // {left, right, up, down}
  function automatic logic [3:0] dirs_of(input logic [7:0] b);
`ifdef NES_PAD_SOCD_EN
    return {b[6] & ~b[7], b[7] & ~b[6], b[4] & ~b[5], b[5] & ~b[4]};
`else
    return {b[6], b[7], b[4], b[5]};
`endif
  endfunction

  task automatic expect_frame(input logic [7:0] b);
    exp_q.push_back({dirs_of(b), b});
  endtask

  always @(negedge clk) begin
    if (reset && valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_e = exp_q.pop_front();
        check("frame_buttons", {24'd0, buttons}, {24'd0, exp_e[7:0]});
        check("frame_dirs", {28'd0, left, right, up, down}, {28'd0, exp_e[11:8]});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_frame(input string name, input int exp_rise, input int exp_vcyc,
                           input logic [7:0] hold, input int chg_pulse, input logic [7:0] chg_val);
    int rise, width, pulses, vcyc, bad, run;
    logic prev_latch, prev_clk;
    bit after, changed;
    rise = -1; width = 0; pulses = 0; vcyc = -1; bad = 0; run = 0;
    after = 0; changed = 0;
    prev_latch = pad_latch;
    prev_clk = pad_clk;
    for (int i = 0; i < 200 && vcyc < 0; i++) begin
      step();
      if (pad_latch) begin
        width++;
        if (!prev_latch) rise = cyc;
        if (pad_clk) bad++;
      end
      if (pad_clk && !prev_clk) pulses++;
      if (chg_pulse > 0 && pulses == chg_pulse && !changed) begin
        pad_btn = chg_val;
        changed = 1;
      end
      if (after) begin
        if (pad_clk == prev_clk) run++;
        else begin
          if (run != HALF) bad++;
          run = 1;
        end
      end else if (prev_latch && !pad_latch) begin
        after = 1;
        run = 1;
      end
      if (valid) vcyc = cyc;
      else if (buttons !== hold) bad++;
      prev_latch = pad_latch;
      prev_clk = pad_clk;
    end
    check({name, "_latch_rise"}, rise, exp_rise);
    check({name, "_latch_width"}, width, LATCH);
    check({name, "_clk_pulses"}, pulses, 8);
    check({name, "_valid_cycle"}, vcyc, exp_vcyc);
    check({name, "_shape_hold_errs"}, bad, 0);
    step();
    check({name, "_valid_one_cycle"}, {31'd0, valid}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rises;
    logic pc;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pad_latch", {31'd0, pad_latch}, 32'd0);
    check("rst_pad_clk", {31'd0, pad_clk}, 32'd0);
    check("rst_buttons", {24'd0, buttons}, 32'd0);
    check("rst_dirs", {28'd0, left, right, up, down}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);

    @(negedge clk);
    reset = 1'b1;
    cyc = 0;

    expect_frame(8'h00);
    run_frame("f1_idle", 65, 101, 8'h00, 0, 8'h00);

    pad_btn = 8'h41;
    expect_frame(8'h41);
    run_frame("f2_a_left", 129, 165, 8'h00, 0, 8'h00);

    // Pad switches to Up after this frame's latch; this frame must still read A+Left.
    expect_frame(8'h41);
    run_frame("f3_midchange", 193, 229, 8'h41, 2, 8'h10);
    expect_frame(8'h10);
    run_frame("f4_up", 257, 293, 8'h41, 0, 8'h00);

    pad_btn = 8'hC0;
    expect_frame(8'hC0);
    run_frame("f5_left_right", 321, 357, 8'h10, 0, 8'h00);

    // Reset in the HIGH phase of bit 3 (fourth pad_clk rise).
    rises = 0;
    pc = pad_clk;
    for (int i = 0; i < 150 && rises < 4; i++) begin
      step();
      if (pad_clk && !pc) rises++;
      pc = pad_clk;
    end
    check("rst_mid_reached_bit3", rises, 4);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_pad_clk", {31'd0, pad_clk}, 32'd0);
    check("rst_mid_pad_latch", {31'd0, pad_latch}, 32'd0);
    check("rst_mid_buttons", {24'd0, buttons}, 32'd0);
    check("rst_mid_valid", {31'd0, valid}, 32'd0);
    repeat (3) @(posedge clk);
    unplugged = 1'b1;
    pad_btn = 8'hFF;
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;

    expect_frame(8'h00);
    run_frame("f7_unplugged", 65, 101, 8'h00, 0, 8'h00);
    expect_frame(8'h00);
    run_frame("f8_unplugged", 129, 165, 8'h00, 0, 8'h00);

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nes_pad_reader.md
# nes_pad_reader

Polls a serial NES-style gamepad on a fixed period. It drives the pad's latch and clock lines and shifts in the 8 button bits. It presents the result as registered, active-high button levels, including `left`/`right`/`up`/`down`. It sits between the board's controller connector and any game logic that consumes four-way direction levels clocked by the 25 MHz pixel clock.

## Interface
- `LATCH_CYCLES`, default 300: latch pulse width in clk cycles (12 µs at 25 MHz).
- `HALF_BIT_CYCLES`, default 150: each low and each high phase of `pad_clk` (6 µs).
- `POLL_CYCLES`, default 416667: poll period (60 Hz); must exceed `LATCH_CYCLES + 16*HALF_BIT_CYCLES + 2`.
- `clk` input 1: single clock for all logic.
- `reset` input 1: asynchronous, active-low reset.
- `pad_data` input 1: serial data from the pad; low means pressed; asynchronous to `clk`.
- `pad_latch` output 1: latch strobe to the pad.
- `pad_clk` output 1: shift clock to the pad.
- `buttons` output 8: {Right, Left, Down, Up, Start, Select, B, A} (bit0 = A); 1 means pressed.
- `left`, `right`, `up`, `down` outputs 1 each: equal `buttons[6]`, `buttons[7]`, `buttons[4]`, `buttons[5]`, subject to the Configuration section.
- `valid` output 1: one-cycle pulse when `buttons` updates.

## Operation
- `pad_data` passes through a 2-flop synchronizer. All sampling uses the synchronized value.
- Free-running poll counter: 0..`POLL_CYCLES`-1. It asserts a poll tick on the cycle it wraps to 0.
- State machine states:
  - IDLE: all strobes low. A poll tick moves to LATCH, with bit index = 0 and phase counter = 0.
  - LATCH: `pad_latch`=1 for `LATCH_CYCLES` cycles, then go to LOW.
  - LOW: `pad_clk`=0 for `HALF_BIT_CYCLES` cycles. On the last cycle, sample the inverted synchronized `pad_data` into shift bit [index], then go to HIGH.
  - HIGH: `pad_clk`=1 for `HALF_BIT_CYCLES` cycles. If index=7, go to DONE; otherwise increment index and go to LOW.
  - DONE: one cycle. Load `buttons` and the direction outputs from the shift register, assert `valid`, then go to IDLE.
- Exactly 8 `pad_clk` pulses per frame. The 8th pulse is issued even though the pad's shift register is exhausted.
- A poll tick that arrives while not in IDLE is dropped. The parameter constraint guarantees this does not occur with legal values.
- `buttons` and the direction outputs hold their last value between frames. They never show a partially shifted frame.
- A pad that is disconnected (`pad_data` pulled high) reads as all zeros.

## Timing
- Reset values: `pad_latch`=0, `pad_clk`=0, `buttons`=8'h00, `left`/`right`/`up`/`down`=0, `valid`=0. The state machine is in IDLE and the poll counter is 0.
- The first poll tick occurs `POLL_CYCLES` cycles after reset deasserts.
- Frame, from poll tick to the `valid` cycle: `LATCH_CYCLES + 16*HALF_BIT_CYCLES + 1` cycles. With defaults this is 2701.
- `pad_latch` rises on the cycle after the poll tick. `pad_clk` never goes high while `pad_latch` is high.
- Sampling latency is 2 cycles of synchronizer plus the half-bit setup. The pad must settle within `HALF_BIT_CYCLES`-3 cycles after a `pad_clk` rise or a `pad_latch` fall.
- Reset asserted mid-frame: all outputs go to reset values asynchronously and the partial frame is discarded. The next frame starts `POLL_CYCLES` cycles after release.
- All outputs come directly from registers.

## Configuration
- `NES_PAD_SOCD_EN` defined: simultaneous opposite directions are neutralised.
  - Left and Right both pressed: `left`=`right`=0.
  - Up and Down both pressed: `up`=`down`=0.
  - `buttons` always carries the raw values.
- `NES_PAD_SOCD_EN` undefined: each direction output equals its raw `buttons` bit.

## Structure
- Package `nes_pad_pkg`:
  - state enum: IDLE, LATCH, LOW, HIGH, DONE;
  - button index constants: `BTN_A`=0 … `BTN_RIGHT`=7;
  - the parameter-constraint check expression.
- One sub-module, `pad_sync`: the 2-flop synchronizer with the same asynchronous active-low reset, which resets to 1 (idle high).
- Everything else (counters, state machine, shift register, output registers) lives in `nes_pad_reader`.

## Test plan
All scenarios use `LATCH_CYCLES`=4, `HALF_BIT_CYCLES`=2, `POLL_CYCLES`=64. The bench pad model is an 8-bit shift register, parallel-loaded on `pad_latch` high, shifting on `pad_clk` rise, and driving the inverted button.
- Reset release, no buttons pressed → first `pad_latch` rise at cycle 65 after release; width 4; 8 `pad_clk` pulses of 2 low / 2 high; `valid` at cycle 64+37; `buttons`=8'h00.
- Pad holds A+Left (8'h41) → after the first frame `buttons`=8'h41, `left`=1, others 0, `valid` for exactly 1 cycle; values unchanged until the next `valid`.
- Pad changes to Up (8'h10) mid-frame, after its latch → the current frame still reports 8'h41; the following frame reports 8'h10, `up`=1.
- Left+Right pressed (8'hC0) → `buttons`=8'hC0. With `NES_PAD_SOCD_EN`: `left`=`right`=0. Without it: both 1.
- Reset asserted during HIGH of bit 3 → `pad_clk`, `pad_latch`, `buttons` are 0 in the same cycle; no `valid` is issued; the next frame starts 64 cycles after release.
- `pad_data` tied high (pad unplugged) → every frame yields `buttons`=8'h00 and `valid` still pulses once per 64 cycles.
